// File: rtl/ring_switch_alloc.sv
// ring_switch_alloc: 3-port ring router switch allocator with per-output round-robin and credit tracking.
// Define RING_SWALLOC_STALL_CNT_EN to add per-output stall counters on stall_cnt.
module ring_switch_alloc #(
  parameter int NUM_PORTS = 3,
  parameter int CREDITS = 4,
  parameter int CNT_W = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       in_valid,
  input  logic [2*NUM_PORTS-1:0]     in_dir,
  output logic [NUM_PORTS-1:0]       in_grant,
  output logic [NUM_PORTS-1:0]       out_valid,
  output logic [2*NUM_PORTS-1:0]     out_sel,
  input  logic [NUM_PORTS-1:0]       credit_ret,
  output logic [CNT_W*NUM_PORTS-1:0] credit_cnt,
`ifdef RING_SWALLOC_STALL_CNT_EN
  output logic [16*NUM_PORTS-1:0]    stall_cnt,
`endif
  output logic                       dir_err
);
  logic [CNT_W-1:0] cred [NUM_PORTS];
  logic [CNT_W-1:0] cred_nx [NUM_PORTS];
  logic [1:0] ptr [NUM_PORTS];
  logic [1:0] win [NUM_PORTS];
  logic [NUM_PORTS-1:0] raw [NUM_PORTS];
  logic [NUM_PORTS-1:0] req [NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt_any, ovf;
  logic [2:0] j;
  logic bad;
  // Searching from lowest priority to highest lets the highest-priority hit overwrite.
  always_comb begin
    gnt_any = '0;
    ovf = '0;
    bad = 1'b0;
    j = '0;
    for (int i = 0; i < NUM_PORTS; i++) bad = bad | (in_valid[i] & (in_dir[2*i+:2] == 2'b11));
    for (int o = 0; o < NUM_PORTS; o++) begin
      raw[o] = '0;
      req[o] = '0;
      gnt[o] = '0;
      win[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        raw[o][i] = in_valid[i] & (in_dir[2*i+:2] == 2'(o)) & ~in_grant[i];
        req[o][i] = raw[o][i] & (cred[o] != '0);
      end
      for (int k = NUM_PORTS-1; k >= 0; k--) begin
        j = {1'b0, ptr[o]} + 3'(k);
        j = (j >= 3'(NUM_PORTS)) ? j - 3'(NUM_PORTS) : j;
        if (req[o][j[1:0]]) begin
          gnt[o] = '0;
          gnt[o][j[1:0]] = 1'b1;
          win[o] = j[1:0];
        end
      end
      gnt_any = gnt_any | gnt[o];
      ovf[o] = credit_ret[o] & ~(|gnt[o]) & (cred[o] == CNT_W'(CREDITS));
      cred_nx[o] = (|gnt[o] & ~credit_ret[o]) ? cred[o] - CNT_W'(1) :
                   (credit_ret[o] & ~(|gnt[o]) & ~ovf[o]) ? cred[o] + CNT_W'(1) : cred[o];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      in_grant <= '0;
      out_valid <= '0;
      out_sel <= '0;
      dir_err <= 1'b0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        cred[o] <= CNT_W'(CREDITS);
        ptr[o] <= '0;
      end
    end else begin
      in_grant <= gnt_any;
      dir_err <= dir_err | bad | (|ovf);
      for (int o = 0; o < NUM_PORTS; o++) begin
        out_valid[o] <= |gnt[o];
        out_sel[2*o+:2] <= win[o];
        cred[o] <= cred_nx[o];
        if (|gnt[o]) ptr[o] <= (win[o] == 2'(NUM_PORTS-1)) ? '0 : win[o] + 2'd1;
      end
    end
  end
`ifdef RING_SWALLOC_STALL_CNT_EN
  logic [15:0] stall [NUM_PORTS];
  // A cycle stalls when someone wants the output but credit is gone or a requester loses.
  always_ff @(posedge clk) begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (rst) stall[o] <= '0;
      else if ((raw[o] != '0) && ((cred[o] == '0) || ($countones(raw[o]) > 1)) && (stall[o] != 16'hFFFF))
        stall[o] <= stall[o] + 16'd1;
    end
  end
`endif
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out
    assign credit_cnt[CNT_W*g+:CNT_W] = cred[g];
`ifdef RING_SWALLOC_STALL_CNT_EN
    assign stall_cnt[16*g+:16] = stall[g];
`endif
  end
endmodule

// File: tb/tb_ring_switch_alloc.sv
// tb_ring_switch_alloc: directed vectors for ring_switch_alloc, checked by a queue-driven monitor.
module tb_ring_switch_alloc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] in_valid = '0, credit_ret = '0, in_grant, out_valid;
  logic [5:0] in_dir = '0, out_sel;
  logic [8:0] credit_cnt;
  logic dir_err;
`ifdef RING_SWALLOC_STALL_CNT_EN
  logic [47:0] stall_cnt;
`endif
  typedef struct {
    string name;
    logic [2:0] g;
    logic [2:0] ov;
    logic [5:0] sel;
    logic [8:0] cnt;
    logic err;
  } exp_t;
  exp_t sbq[$];
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  ring_switch_alloc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_dir(in_dir),
    .in_grant(in_grant), .out_valid(out_valid), .out_sel(out_sel),
    .credit_ret(credit_ret), .credit_cnt(credit_cnt),
`ifdef RING_SWALLOC_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .dir_err(dir_err)
  );

  task automatic vec(input string name, input logic r, input logic [2:0] v, input logic [5:0] d,
                     input logic [2:0] cr, input logic [2:0] g, input logic [2:0] ov,
                     input logic [5:0] sel, input logic [8:0] cnt, input logic err);
    @(negedge clk);
    rst = r;
    in_valid = v;
    in_dir = d;
    credit_ret = cr;
    sbq.push_back('{name, g, ov, sel, cnt, err});
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_vec++;
      if ({in_grant, out_valid, out_sel, credit_cnt, dir_err} !== {e.g, e.ov, e.sel, e.cnt, e.err}) begin
        n_err++;
        $display("FAIL %s: got grant=%b ov=%b sel=%b cnt=%o err=%b, want grant=%b ov=%b sel=%b cnt=%o err=%b",
                 e.name, in_grant, out_valid, out_sel, credit_cnt, dir_err, e.g, e.ov, e.sel, e.cnt, e.err);
      end
    end
  end

  initial begin
    //     name        rst valid  dir        cret    grant   ov      sel        cnt     err
    vec("reset0",     1, 3'b000, 6'b000000, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o444, 0);
    vec("reset1",     1, 3'b000, 6'b000000, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o444, 0);
    vec("idle",       0, 3'b000, 6'b000000, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o444, 0);
    vec("single",     0, 3'b001, 6'b000001, 3'b000, 3'b001, 3'b010, 6'b000000, 9'o434, 0);
    vec("single_end", 0, 3'b000, 6'b000001, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o434, 0);
    vec("single_ret", 0, 3'b000, 6'b000000, 3'b010, 3'b000, 3'b000, 6'b000000, 9'o444, 0);
    vec("west_g0",    0, 3'b111, 6'b101010, 3'b100, 3'b001, 3'b100, 6'b000000, 9'o444, 0);
    vec("west_g1",    0, 3'b111, 6'b101010, 3'b100, 3'b010, 3'b100, 6'b010000, 9'o444, 0);
    vec("west_g2",    0, 3'b111, 6'b101010, 3'b100, 3'b100, 3'b100, 6'b100000, 9'o444, 0);
    vec("west_g3",    0, 3'b111, 6'b101010, 3'b100, 3'b001, 3'b100, 6'b000000, 9'o444, 0);
    vec("west_g4",    0, 3'b111, 6'b101010, 3'b100, 3'b010, 3'b100, 6'b010000, 9'o444, 0);
    vec("west_g5",    0, 3'b111, 6'b101010, 3'b100, 3'b100, 3'b100, 6'b100000, 9'o444, 0);
    vec("west_end",   0, 3'b000, 6'b000000, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o444, 0);
    vec("exh_g1",     0, 3'b010, 6'b000000, 3'b000, 3'b010, 3'b001, 6'b000001, 9'o443, 0);
    vec("exh_m1",     0, 3'b010, 6'b000000, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o443, 0);
    vec("exh_g2",     0, 3'b010, 6'b000000, 3'b000, 3'b010, 3'b001, 6'b000001, 9'o442, 0);
    vec("exh_m2",     0, 3'b010, 6'b000000, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o442, 0);
    vec("exh_g3",     0, 3'b010, 6'b000000, 3'b000, 3'b010, 3'b001, 6'b000001, 9'o441, 0);
    vec("exh_m3",     0, 3'b010, 6'b000000, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o441, 0);
    vec("exh_g4",     0, 3'b010, 6'b000000, 3'b000, 3'b010, 3'b001, 6'b000001, 9'o440, 0);
    vec("exh_m4",     0, 3'b010, 6'b000000, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o440, 0);
    vec("exh_stall0", 0, 3'b010, 6'b000000, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o440, 0);
    vec("exh_stall1", 0, 3'b010, 6'b000000, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o440, 0);
    vec("exh_ret",    0, 3'b010, 6'b000000, 3'b001, 3'b000, 3'b000, 6'b000000, 9'o441, 0);
    vec("exh_g5",     0, 3'b010, 6'b000000, 3'b000, 3'b010, 3'b001, 6'b000001, 9'o440, 0);
    vec("exh_end",    0, 3'b000, 6'b000000, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o440, 0);
    vec("exh_r1",     0, 3'b000, 6'b000000, 3'b001, 3'b000, 3'b000, 6'b000000, 9'o441, 0);
    vec("exh_r2",     0, 3'b000, 6'b000000, 3'b001, 3'b000, 3'b000, 6'b000000, 9'o442, 0);
    vec("exh_r3",     0, 3'b000, 6'b000000, 3'b001, 3'b000, 3'b000, 6'b000000, 9'o443, 0);
    vec("exh_r4",     0, 3'b000, 6'b000000, 3'b001, 3'b000, 3'b000, 6'b000000, 9'o444, 0);
    vec("sim_g1",     0, 3'b001, 6'b000001, 3'b000, 3'b001, 3'b010, 6'b000000, 9'o434, 0);
    vec("sim_m1",     0, 3'b001, 6'b000001, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o434, 0);
    vec("sim_g2",     0, 3'b001, 6'b000001, 3'b000, 3'b001, 3'b010, 6'b000000, 9'o424, 0);
    vec("sim_m2",     0, 3'b001, 6'b000001, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o424, 0);
    vec("sim_both",   0, 3'b001, 6'b000001, 3'b010, 3'b001, 3'b010, 6'b000000, 9'o424, 0);
    vec("sim_end",    0, 3'b000, 6'b000000, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o424, 0);
    vec("sim_r1",     0, 3'b000, 6'b000000, 3'b010, 3'b000, 3'b000, 6'b000000, 9'o434, 0);
    vec("sim_r2",     0, 3'b000, 6'b000000, 3'b010, 3'b000, 3'b000, 6'b000000, 9'o444, 0);
    vec("ovf",        0, 3'b000, 6'b000000, 3'b100, 3'b000, 3'b000, 6'b000000, 9'o444, 1);
    vec("ovf_sticky", 0, 3'b000, 6'b000000, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o444, 1);
    vec("clr_rst",    1, 3'b000, 6'b000000, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o444, 0);
    vec("ill0",       0, 3'b100, 6'b110000, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o444, 1);
    vec("ill1",       0, 3'b100, 6'b110000, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o444, 1);
    vec("ill2",       0, 3'b100, 6'b110000, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o444, 1);
    vec("ill_drop",   0, 3'b000, 6'b000000, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o444, 1);
    vec("ill_rst",    1, 3'b000, 6'b000000, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o444, 0);
    vec("ill_idle",   0, 3'b000, 6'b000000, 3'b000, 3'b000, 3'b000, 6'b000000, 9'o444, 0);
    vec("loc_g0",     0, 3'b101, 6'b000000, 3'b000, 3'b001, 3'b001, 6'b000000, 9'o443, 0);
    vec("loc_g2",     0, 3'b101, 6'b000000, 3'b000, 3'b100, 3'b001, 6'b000010, 9'o442, 0);
    vec("loc_r1",     0, 3'b000, 6'b000000, 3'b001, 3'b000, 3'b000, 6'b000000, 9'o443, 0);
    vec("loc_r2",     0, 3'b000, 6'b000000, 3'b001, 3'b000, 3'b000, 6'b000000, 9'o444, 0);
    @(posedge clk);
    #2;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected responses left unchecked, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ring_switch_alloc.md
Name: ring_switch_alloc

Overview:
- Switch allocator for one ring router with three ports: 0 = local, 1 = east, 2 = west.
- Each input port presents its head packet and the 2-bit output direction from its route-compute stage.
- The allocator grants at most one input per output and at most one output per input per cycle.
- It tracks per-output downstream credits and drives the crossbar selects.
- It sits between the input buffers/route-compute stage and the crossbar/output links.

Parameters:
- NUM_PORTS, 3, number of ports; fixed at 3 (local/east/west).
- CREDITS, 4, initial and maximum credit count per output (downstream buffer depth).
- CNT_W, 3, credit counter width; must hold CREDITS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  3  bit i = input i has a head packet requesting.
- in_dir  input  6  bits [2i+1:2i] = requested output of input i (00 local, 01 east, 10 west, 11 illegal).
- in_grant  output  3  bit i = input i won; pop the head this cycle. One-hot or zero per output.
- out_valid  output  3  bit o = output o carries a packet this cycle.
- out_sel  output  6  bits [2o+1:2o] = index of the input driving output o; 00 when out_valid[o]=0.
- credit_ret  input  3  bit o = downstream of output o freed one slot.
- credit_cnt  output  9  bits [3o+2:3o] = current credits of output o.
- dir_err  output  1  sticky; set on a valid request with in_dir=11, or on a credit overflow.

Behaviour:
- Reset values (rst=1 at an edge):
  - in_grant=0, out_valid=0, out_sel=0.
  - All credit counters = CREDITS.
  - All round-robin pointers = 0.
  - dir_err=0.
  - Reset mid-transfer drops any pending grant; the next cycle's outputs are the reset values.
- Request vector:
  - req[o][i] = in_valid[i] & (in_dir[i]==o) & ~in_grant[i] & (credit[o]!=0).
  - Masking by the registered in_grant[i] stops the same head from being granted twice. A granted input may re-request at the earliest one cycle after its grant pulse.
  - in_dir=11 is never granted and sets dir_err.
- Arbitration (combinational from registered state):
  - Per output o: round-robin search starting at ptr[o], order ptr, ptr+1, ptr+2 mod 3. The first set req wins.
  - Each input requests exactly one output, so no input-side conflict exists.
- Latency: results are registered. A request sampled at edge t gives in_grant/out_valid/out_sel valid for exactly one cycle after edge t. Requester holds in_valid/in_dir stable until its grant pulse.
- Pointer update: on a grant to input i for output o, ptr[o] <= (i+1) mod 3. No grant leaves ptr[o] unchanged.
- Credits, per output and per cycle:
  - Grant without credit_ret: decrement.
  - credit_ret without grant: increment.
  - Both together: unchanged.
  - An increment at CREDITS saturates and sets dir_err.
  - A count of 0 blocks requests to that output until a credit_ret arrives; the request is eligible at the edge after the return.
- Local ejection uses output 0 and obeys the same credit rule, with credit_ret[0] from the ejection sink.
- dir_err clears only on rst.

Optional Feature:
- Macro: RING_SWALLOC_STALL_CNT_EN.
- Defined: adds output stall_cnt (48 bits: 16 per output).
  - Counter o increments, saturating at 0xFFFF, each cycle output o has at least one requester (ignoring credits) and either no credit or more than one requester. Losers count as a stall.
  - Reset to 0 by rst.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: hold rst 2 cycles, then release. Expect in_grant=000, out_valid=000, credit_cnt=each 4, dir_err=0.
- Single request: in_valid=001, in_dir[1:0]=01 (local to east). One cycle later expect in_grant=001, out_valid=010, out_sel[3:2]=00, credit_cnt[5:3]=3.
- Three-way contention for west: all inputs request 10 continuously, re-requesting after each grant. Over 6 cycles expect the grant order 0,1,2,0,1,2, one grant per cycle.
- Credit exhaustion: east requests local 5 times with no credit_ret. Expect 4 grants, then stall with credit_cnt[2:0]=0. Pulse credit_ret[0]; expect a grant one cycle after the return is sampled.
- Simultaneous grant and return: at credit 2, grant output 1 while credit_ret[1]=1. Expect credit stays 2. Also pulse credit_ret[2] at count 4; expect it stays 4 and dir_err=1.
- Illegal dir: in_valid=100, in_dir[5:4]=11. Expect no grant ever and dir_err=1. Then assert rst for 1 cycle; expect dir_err=0.
